// File: rtl/cpu86_e8086_mem_ctrl.sv
// -----------------------------------------------------------------------------
// cpu86_e8086_mem_ctrl
//
// Request adapter and read-return buffer placed directly in front of the e8086
// memory model.
//   - CPU commands (valid/ready) are packed into a 64-bit memory request word
//     and held in a single register slice. No combinational path exists from
//     s_cmd_* to m_axis_req_*.
//   - The memory response channel has no backpressure. A credit counter
//     therefore limits the number of outstanding reads to the FIFO depth.
//   - Read data is buffered in a FIFO and returned in order on a valid/ready
//     channel.
//
// Request word layout:
//   [31:0]  write data (0 for reads)
//   [56:32] word address
//   [57]    write enable
//   [61:58] byte mask (0 for reads)
//   [63:62] 0
//
// Ports:
//   clk, reset                       clock and async active-high reset
//   s_cmd_t{valid,ready,we,addr,mask,data}   CPU command channel
//   m_axis_req_t{valid,ready,data}   packed request to memory
//   s_axis_res_t{valid,data}         memory read response (no ready)
//   m_rd_t{valid,ready,data}         read data returned to the CPU
//   err                              sticky protocol error; present only
//                                    with CPU86_MEM_CTRL_ERR_EN defined
//
// Optional feature macro: CPU86_MEM_CTRL_ERR_EN
// -----------------------------------------------------------------------------
module cpu86_e8086_mem_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 25
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_cmd_tvalid,
    output logic              s_cmd_tready,
    input  logic              s_cmd_twe,
    input  logic [ADDR_W-1:0] s_cmd_taddr,
    input  logic [3:0]        s_cmd_tmask,
    input  logic [31:0]       s_cmd_tdata,
    output logic              m_axis_req_tvalid,
    input  logic              m_axis_req_tready,
    output logic [63:0]       m_axis_req_tdata,
    input  logic              s_axis_res_tvalid,
    input  logic [31:0]       s_axis_res_tdata,
    output logic              m_rd_tvalid,
    input  logic              m_rd_tready,
    output logic [31:0]       m_rd_tdata
`ifdef CPU86_MEM_CTRL_ERR_EN
    ,
    output logic              err
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic              r_req_valid;
    logic [63:0]       r_req_data;
    logic [CW-1:0]     r_credits;
    logic [CW-1:0]     r_count;
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [31:0]       r_mem [FIFO_DEPTH];

    logic              w_stage_free;
    logic              w_cmd_ready;
    logic              w_cmd_acc;
    logic              w_rd_acc;
    logic              w_pop;
    logic              w_full;
    logic              w_push;
    logic [3:0]        w_mask;
    logic [31:0]       w_data;
    logic [63:0]       w_packed;

    // The slice can take a new word when it is empty or is being drained this cycle.
    assign w_stage_free = ~r_req_valid | m_axis_req_tready;
    assign w_cmd_ready  = w_stage_free & (s_cmd_twe | (r_credits < DEPTH_C));
    assign w_cmd_acc    = s_cmd_tvalid & w_cmd_ready;
    assign w_rd_acc     = w_cmd_acc & ~s_cmd_twe;

    assign w_pop  = (r_count != '0) & m_rd_tready;
    assign w_full = (r_count == DEPTH_C);
    // A push into a full FIFO is only legal when a pop frees a slot in the same cycle.
    // Otherwise the word is dropped rather than corrupting the head entry.
    assign w_push = s_axis_res_tvalid & (~w_full | w_pop);

    assign w_mask   = s_cmd_twe ? s_cmd_tmask : 4'h0;
    assign w_data   = s_cmd_twe ? s_cmd_tdata : 32'h0;
    assign w_packed = {2'b00, w_mask, s_cmd_twe, s_cmd_taddr, w_data};

    assign s_cmd_tready      = w_cmd_ready;
    assign m_axis_req_tvalid = r_req_valid;
    assign m_axis_req_tdata  = r_req_data;
    assign m_rd_tvalid       = (r_count != '0);
    assign m_rd_tdata        = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req_valid <= 1'b0;
        end else if (w_cmd_acc) begin
            r_req_valid <= 1'b1;
        end else if (m_axis_req_tready) begin
            r_req_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_cmd_acc) begin
            r_req_data <= w_packed;
        end
    end

    // Credits cover every read from acceptance until the CPU pops its data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_credits <= '0;
        end else begin
            case ({w_rd_acc, w_pop})
                2'b10:   r_credits <= r_credits + CW'(1);
                2'b01:   r_credits <= r_credits - CW'(1);
                default: r_credits <= r_credits;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_axis_res_tdata;
        end
    end

`ifdef CPU86_MEM_CTRL_ERR_EN
    logic r_err;

    // Credits equal to FIFO occupancy means no read is in flight, so any response is unsolicited.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (s_axis_res_tvalid &
                     ((r_credits == r_count) | (w_full & ~w_pop))) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_cpu86_e8086_mem_ctrl.sv
module tb_cpu86_e8086_mem_ctrl;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        s_cmd_tvalid;
    logic        s_cmd_tready;
    logic        s_cmd_twe;
    logic [24:0] s_cmd_taddr;
    logic [3:0]  s_cmd_tmask;
    logic [31:0] s_cmd_tdata;
    logic        m_axis_req_tvalid;
    logic        m_axis_req_tready;
    logic [63:0] m_axis_req_tdata;
    logic        s_axis_res_tvalid;
    logic [31:0] s_axis_res_tdata;
    logic        m_rd_tvalid;
    logic        m_rd_tready;
    logic [31:0] m_rd_tdata;
`ifdef CPU86_MEM_CTRL_ERR_EN
    logic        err;
`endif

    cpu86_e8086_mem_ctrl #(.FIFO_DEPTH(DEPTH), .ADDR_W(25)) dut (
        .clk               (clk),
        .reset             (reset),
        .s_cmd_tvalid      (s_cmd_tvalid),
        .s_cmd_tready      (s_cmd_tready),
        .s_cmd_twe         (s_cmd_twe),
        .s_cmd_taddr       (s_cmd_taddr),
        .s_cmd_tmask       (s_cmd_tmask),
        .s_cmd_tdata       (s_cmd_tdata),
        .m_axis_req_tvalid (m_axis_req_tvalid),
        .m_axis_req_tready (m_axis_req_tready),
        .m_axis_req_tdata  (m_axis_req_tdata),
        .s_axis_res_tvalid (s_axis_res_tvalid),
        .s_axis_res_tdata  (s_axis_res_tdata),
        .m_rd_tvalid       (m_rd_tvalid),
        .m_rd_tready       (m_rd_tready),
        .m_rd_tdata        (m_rd_tdata)
`ifdef CPU86_MEM_CTRL_ERR_EN
        ,
        .err               (err)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Memory contents as seen by the reference: a fixed function of the address.
    function automatic logic [31:0] mem_f(input logic [24:0] a);
        if (a == 25'h100) return 32'hDEADBEEF;
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A3C3C;
    endfunction

    // Request word built arithmetically from the field positions.
    function automatic logic [63:0] pack(input logic we, input logic [24:0] a,
                                         input logic [3:0] m, input logic [31:0] d);
        logic [63:0] mm, dd;
        mm = we ? 64'(m) : 64'd0;
        dd = we ? 64'(d) : 64'd0;
        return dd + (64'(a) << 32) + (64'(we) << 57) + (mm << 58);
    endfunction

    // Ready generators. mode: 0 low, 1 high, 2 random, 3 toggle / manual.
    int mreq_mode = 1;
    int rd_mode   = 1;
    bit rd_manual = 1'b0;

    initial begin
        int mm, rm, c;
        bit man;
        m_axis_req_tready = 1'b1;
        m_rd_tready = 1'b1;
        forever begin
            @(posedge clk);
            mm = mreq_mode; rm = rd_mode; c = cyc; man = rd_manual;
            #1;
            case (mm)
                0: m_axis_req_tready = 1'b0;
                2: m_axis_req_tready = ($urandom_range(0, 3) != 0);
                3: m_axis_req_tready = ((c % 2) == 0);
                default: m_axis_req_tready = 1'b1;
            endcase
            case (rm)
                0: m_rd_tready = 1'b0;
                2: m_rd_tready = ($urandom_range(0, 4) < 3);
                3: m_rd_tready = man;
                default: m_rd_tready = 1'b1;
            endcase
        end
    end

    // Memory model: answers each read two cycles after its request handshake.
    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;
    resp_t       pend[$];
    bit          nxt_v = 1'b0;
    logic [31:0] nxt_d = '0;
    bit          inj = 1'b0;

    initial forever begin
        resp_t r;
        @(negedge clk);
        if (reset) begin
            pend.delete();
            nxt_v = 1'b0;
        end else begin
            if (m_axis_req_tvalid && m_axis_req_tready && !m_axis_req_tdata[57]) begin
                r.due  = cyc + 2;
                r.data = mem_f(m_axis_req_tdata[56:32]);
                pend.push_back(r);
            end
            nxt_v = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc + 1) begin
                r = pend.pop_front();
                nxt_v = 1'b1;
                nxt_d = r.data;
            end
        end
    end

    initial begin
        bit v, i;
        logic [31:0] d;
        s_axis_res_tvalid = 1'b0;
        s_axis_res_tdata  = '0;
        forever begin
            @(posedge clk);
            v = nxt_v; d = nxt_d; i = inj;
            #1;
            s_axis_res_tvalid = v | i;
            s_axis_res_tdata  = v ? d : 32'hBAD0_0000;
        end
    end

    // Scoreboard: expectations pushed on command acceptance, popped on output handshakes.
    logic [63:0] exp_req[$];
    logic [31:0] exp_rd[$];
    int          outstanding = 0;

    initial begin
        bit          prev_req_stall, prev_rd_stall;
        logic [63:0] prev_req_data;
        logic [31:0] prev_rd_data;
        logic        exp_rdy;
        prev_req_stall = 0; prev_rd_stall = 0;
        prev_req_data = '0; prev_rd_data = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_req.delete();
                exp_rd.delete();
                outstanding = 0;
                prev_req_stall = 0;
                prev_rd_stall = 0;
            end else begin
                if (s_cmd_tvalid) begin
                    exp_rdy = (!m_axis_req_tvalid || m_axis_req_tready) &&
                              (s_cmd_twe || outstanding < DEPTH);
                    check("cmd_tready", 64'(s_cmd_tready), 64'(exp_rdy));
                    if (s_cmd_tready) begin
                        exp_req.push_back(pack(s_cmd_twe, s_cmd_taddr, s_cmd_tmask, s_cmd_tdata));
                        if (!s_cmd_twe) begin
                            exp_rd.push_back(mem_f(s_cmd_taddr));
                            outstanding++;
                        end
                    end
                end
                if (prev_req_stall) begin
                    check("req_hold_valid", 64'(m_axis_req_tvalid), 64'd1);
                    check("req_hold_data", m_axis_req_tdata, prev_req_data);
                end
                if (m_axis_req_tvalid && m_axis_req_tready) begin
                    if (exp_req.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL req_extra actual=0x%0h required=none", m_axis_req_tdata);
                    end else begin
                        check("req_word", m_axis_req_tdata, exp_req.pop_front());
                    end
                end
                prev_req_stall = m_axis_req_tvalid && !m_axis_req_tready;
                prev_req_data  = m_axis_req_tdata;
                if (prev_rd_stall) begin
                    check("rd_hold_valid", 64'(m_rd_tvalid), 64'd1);
                    check("rd_hold_data", 64'(m_rd_tdata), 64'(prev_rd_data));
                end
                if (m_rd_tvalid && m_rd_tready) begin
                    if (exp_rd.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL rd_extra actual=0x%0h required=none", m_rd_tdata);
                    end else begin
                        check("rd_data", 64'(m_rd_tdata), 64'(exp_rd.pop_front()));
                    end
                    outstanding--;
                end
                prev_rd_stall = m_rd_tvalid && !m_rd_tready;
                prev_rd_data  = m_rd_tdata;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 with tvalid dropped.
    task automatic send_cmd(input logic we, input logic [24:0] a, input logic [3:0] m,
                            input logic [31:0] d, input int bound,
                            output bit acc, output int acc_cyc);
        acc = 0;
        acc_cyc = -1;
        s_cmd_tvalid = 1'b1;
        s_cmd_twe    = we;
        s_cmd_taddr  = a;
        s_cmd_tmask  = m;
        s_cmd_tdata  = d;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (s_cmd_tready) begin
                acc = 1;
                acc_cyc = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
        s_cmd_tvalid = 1'b0;
    endtask

    task automatic wait_quiet(input int bound);
        bit q;
        q = 0;
        for (int i = 0; i < bound; i++) begin
            if (exp_req.size() == 0 && exp_rd.size() == 0 && pend.size() == 0 && !m_rd_tvalid) begin
                q = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (!q) begin
            errors++;
            $display("FAIL drain actual=req:%0d rd:%0d required=empty", exp_req.size(), exp_rd.size());
        end
    endtask

    task automatic reads_count(input int n, input int bound, output int nacc);
        bit a;
        int c;
        nacc = 0;
        for (int i = 0; i < n; i++) begin
            send_cmd(1'b0, 25'($urandom), 4'($urandom), $urandom, bound, a, c);
            if (a) nacc++;
        end
    endtask

    initial begin
        bit acc;
        int t0, seen, nacc, rdv;
        s_cmd_tvalid = 1'b0;
        s_cmd_twe = 1'b0;
        s_cmd_taddr = '0;
        s_cmd_tmask = '0;
        s_cmd_tdata = '0;
        reset = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_valid", 64'(m_axis_req_tvalid), 64'd0);
        check("rst_rd_valid", 64'(m_rd_tvalid), 64'd0);
`ifdef CPU86_MEM_CTRL_ERR_EN
        check("rst_err", 64'(err), 64'd0);
`endif
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_cmd_tready", 64'(s_cmd_tready), 64'd1);
        @(posedge clk);
        #1;

        // Single read latency: request N+1, data N+4.
        send_cmd(1'b0, 25'h100, 4'hF, 32'hFFFF_FFFF, 20, acc, t0);
        check("lat_accept", 64'(acc), 64'd1);
        seen = -1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            else @(negedge clk);
            if (i == 0) check("lat_req_valid", 64'(m_axis_req_tvalid), 64'd1);
            if (m_rd_tvalid) begin
                seen = cyc;
                break;
            end
        end
        check("lat_rd_cycle", 64'(seen - t0), 64'd4);
        check("lat_rd_data", 64'(m_rd_tdata), 64'hDEADBEEF);
        @(posedge clk);
        #1;
        wait_quiet(50);

        // Write packing, no read return.
        send_cmd(1'b1, 25'h1FFFFFF, 4'hA, 32'h12345678, 20, acc, t0);
        check("wr_accept", 64'(acc), 64'd1);
        seen = 0;
        rdv = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (m_axis_req_tvalid && m_axis_req_tready && seen == 0) begin
                seen = 1;
                check("wr_word", m_axis_req_tdata, 64'h2BFFFFFF_12345678);
            end
            rdv += int'(m_rd_tvalid);
        end
        check("wr_seen", 64'(seen), 64'd1);
        check("wr_no_rd", 64'(rdv), 64'd0);
        @(posedge clk);
        #1;

        // Credit limit with CPU not accepting read data.
        rd_mode = 0;
        reads_count(6, 8, nacc);
        check("credit_accepts", 64'(nacc), 64'(DEPTH));
        send_cmd(1'b1, 25'h00ABC, 4'h3, 32'hCAFEF00D, 8, acc, t0);
        check("credit_write_ok", 64'(acc), 64'd1);
        rd_mode = 1;
        reads_count(2, 30, nacc);
        check("credit_resume", 64'(nacc), 64'd2);
        wait_quiet(100);

        // Toggling memory ready with a mixed stream.
        mreq_mode = 3;
        for (int i = 0; i < 8; i++) begin
            send_cmd(1'(i % 3 == 1), 25'($urandom), 4'($urandom), $urandom, 20, acc, t0);
            check("toggle_accept", 64'(acc), 64'd1);
        end
        mreq_mode = 1;
        wait_quiet(100);

        // Read accept and pop in the same cycle at credits = DEPTH-1.
        rd_manual = 1'b0;
        rd_mode = 3;
        reads_count(DEPTH - 1, 8, nacc);
        check("sim_prefill", 64'(nacc), 64'(DEPTH - 1));
        repeat (6) @(posedge clk);
        #1;
        rd_manual = 1'b1;
        @(posedge clk);
        #1;
        rd_manual = 1'b0;
        send_cmd(1'b0, 25'h0055, 4'h0, 32'h0, 1, acc, t0);
        check("sim_accept", 64'(acc), 64'd1);
        reads_count(2, 6, nacc);
        check("sim_credit_left", 64'(nacc), 64'd1);
        rd_mode = 1;
        wait_quiet(100);

        // Reset with reads outstanding.
        rd_mode = 0;
        reads_count(3, 5, nacc);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("amid_req_valid", 64'(m_axis_req_tvalid), 64'd0);
        check("amid_rd_valid", 64'(m_rd_tvalid), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("post_cmd_tready", 64'(s_cmd_tready), 64'd1);
        @(posedge clk);
        #1;
        reads_count(DEPTH + 1, 8, nacc);
        check("post_credit_zero", 64'(nacc), 64'(DEPTH));
        rd_mode = 1;
        wait_quiet(100);

        // Randomized traffic.
        mreq_mode = 2;
        rd_mode = 2;
        for (int i = 0; i < 250; i++) begin
            send_cmd(1'($urandom_range(0, 2) == 0), 25'($urandom), 4'($urandom), $urandom,
                     200, acc, t0);
            if (!acc) begin
                checks++; errors++;
                $display("FAIL rand_accept actual=stalled required=accepted");
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        mreq_mode = 1;
        rd_mode = 1;
        wait_quiet(500);

`ifdef CPU86_MEM_CTRL_ERR_EN
        check("err_clean", 64'(err), 64'd0);
        rd_mode = 0;
        inj = 1'b1;
        @(posedge clk);
        #1;
        inj = 1'b0;
        repeat (2) @(negedge clk);
        check("err_unsolicited", 64'(err), 64'd1);
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        check("err_cleared", 64'(err), 64'd0);
        rd_mode = 1;
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
